// File: rtl/down_timer.sv
// down_timer -- loadable down-counter with terminal-count pulse, optional auto-reload.
//
// A LOAD captures DATA into the count and reload registers and starts the
// count if DATA is non-zero. The count falls by one each enabled cycle in
// RUN. The decrement that moves the count away from 1 raises TC for one
// cycle. It then either stops in DONE with COUNT=0, or reloads and stays
// in RUN if RELOAD is set.
//
// Ports:
//   clk_i      sole clock, rising edge
//   rst_ni     asynchronous active-low reset; release is synchronized internally
//   enable_i   count-down enable (only honoured in RUN)
//   load_i     synchronous load of data_i; wins over everything else
//   data_i     start / reload value
//   reload_i   auto-reload select, sampled on the terminal decrement
//   count_o    current count (registered)
//   tc_o       terminal-count pulse, one cycle wide (registered)
//   busy_o     high while in RUN (registered)
module down_timer #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             reload_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Reset synchronizer. Assertion propagates straight through the async clear.
  // Release needs SYNC_STAGES rising edges with rst_ni high before rst_int_n
  // goes high. A LOAD at any of those edges is therefore ignored.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_int_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_int_n = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Datapath / control state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;        // TC only survives the cycle after a terminal decrement

    if (load_i) begin
      // Load overrides enable and any coincident terminal decrement.
      count_d  = data_i;
      reload_d = data_i;
      state_d  = (data_i != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (enable_i) begin
            if (count_q == ONE) begin
              tc_d = 1'b1;
              if (reload_i) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end else if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              // Count of zero in RUN should not occur. Park in DONE without wrapping.
              state_d = DONE;
            end
          end
        end
        IDLE, DONE: ;       // enable ignored, count held; exit only via load
        default: state_d = IDLE;
      endcase
    end

    // busy tracks the state register on the same edge
    busy_d = (state_d == RUN);
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer. A cycle-level reference model pushes the expected
// {count, tc, busy} for every clock edge into a scoreboard queue. After the
// edge, the entry is popped and compared against the DUT outputs.
module tb_down_timer;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         enable_i;
  logic         load_i;
  logic [W-1:0] data_i;
  logic         reload_i;
  logic [W-1:0] count_o;
  logic         tc_o;
  logic         busy_o;

  down_timer #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .load_i   (load_i),
    .data_i   (data_i),
    .reload_i (reload_i),
    .count_o  (count_o),
    .tc_o     (tc_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state (0=IDLE, 1=RUN, 2=DONE)
  int           m_sync = 0;
  int           m_st   = 0;
  logic [W-1:0] m_cnt  = '0;
  logic [W-1:0] m_rel  = '0;
  logic         m_tc   = 1'b0;

  task automatic model_reset();
    m_sync = 0; m_st = 0; m_cnt = '0; m_rel = '0; m_tc = 1'b0;
  endtask

  // One clock: drive inputs, predict, push, wait for the edge, pop, compare.
  task automatic cyc(input string tag, input logic ld, input logic en,
                     input logic rl, input logic [W-1:0] d);
    exp_t e, o;
    load_i = ld; enable_i = en; reload_i = rl; data_i = d;
    if (!rst_ni) begin
      model_reset();
    end else if (m_sync < SYNC) begin
      m_sync++;                       // still inside the synchronized reset
    end else if (ld) begin
      m_cnt = d; m_rel = d; m_tc = 1'b0;
      m_st  = (d != 0) ? 1 : 0;
    end else begin
      m_tc = 1'b0;
      if (m_st == 1 && en) begin
        if (m_cnt == 1) begin
          m_tc = 1'b1;
          if (rl) m_cnt = m_rel;
          else begin m_cnt = '0; m_st = 2; end
        end else if (m_cnt > 1) begin
          m_cnt = m_cnt - 1'b1;
        end
      end
    end
    e.cnt = m_cnt; e.tc = m_tc; e.busy = (m_st == 1);
    sb.push_back(e);
    @(posedge clk_i); #1;
    o = sb.pop_front();
    chk({tag, ".count"}, 32'(count_o), 32'(o.cnt));
    chk({tag, ".tc"},    32'(tc_o),    32'(o.tc));
    chk({tag, ".busy"},  32'(busy_o),  32'(o.busy));
  endtask

  int tc_seen;

  initial begin
    rst_ni = 1'b0; enable_i = 1'b0; load_i = 1'b0; data_i = '0; reload_i = 1'b0;
    model_reset();
    #1;
    chk("rst.count", 32'(count_o), 0);
    chk("rst.busy",  32'(busy_o),  0);

    // held in reset: load/enable must do nothing
    repeat (3) cyc("inrst", 1'b1, 1'b1, 1'b0, 8'd9);

    // release: edge 1 and edge 2 are still in reset, edge 3 loads
    @(negedge clk_i); rst_ni = 1'b1;
    cyc("rel1", 1'b1, 1'b0, 1'b0, 8'd4);
    cyc("rel2", 1'b0, 1'b0, 1'b0, 8'd4);
    cyc("rel3", 1'b1, 1'b0, 1'b0, 8'd4);
    chk("rel3.loaded", 32'(count_o), 4);

    // load 3, no reload: 3,2,1,0 with TC only on reaching 0; then 5 cycles at 0
    cyc("l3", 1'b1, 1'b0, 1'b0, 8'd3);
    repeat (3) cyc("dn3", 1'b0, 1'b1, 1'b0, 8'd0);
    chk("dn3.zero_tc", 32'({count_o, tc_o, busy_o}), 32'({8'd0, 1'b1, 1'b0}));
    repeat (5) cyc("done", 1'b0, 1'b1, 1'b0, 8'd0);

    // auto-reload with value 2
    cyc("l2r", 1'b1, 1'b0, 1'b1, 8'd2);
    tc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc("rl2", 1'b0, 1'b1, 1'b1, 8'd0);
      if (tc_o) tc_seen++;
    end
    chk("rl2.tc_count", 32'(tc_seen), 3);

    // reload value 1: TC every cycle, count stays 1
    cyc("l1r", 1'b1, 1'b0, 1'b1, 8'd1);
    repeat (4) cyc("rl1", 1'b0, 1'b1, 1'b1, 8'd0);

    // enable gating, then a load that collides with the terminal decrement
    cyc("l5", 1'b1, 1'b0, 1'b0, 8'd5);
    cyc("en1", 1'b0, 1'b1, 1'b0, 8'd0);
    cyc("en0", 1'b0, 1'b0, 1'b0, 8'd0);
    cyc("en1b", 1'b0, 1'b1, 1'b0, 8'd0);
    chk("gate.count", 32'(count_o), 3);
    repeat (2) cyc("to1", 1'b0, 1'b1, 1'b0, 8'd0);
    cyc("ldcol", 1'b1, 1'b1, 1'b0, 8'd9);
    chk("ldcol.count", 32'({count_o, tc_o}), 32'({8'd9, 1'b0}));

    // load of zero: idle, no TC under enable
    cyc("l0", 1'b1, 1'b1, 1'b1, 8'd0);
    repeat (4) cyc("idle0", 1'b0, 1'b1, 1'b1, 8'd0);

    // full-range count from 255 down to terminal
    cyc("lff", 1'b1, 1'b0, 1'b0, 8'hFF);
    repeat (256) cyc("dnff", 1'b0, 1'b1, 1'b0, 8'd0);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc("rnd", ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
          W'($urandom_range(0, 6)));

    // asynchronous reset between edges at count 0x80
    cyc("l80", 1'b1, 1'b0, 1'b0, 8'h80);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("arst.count", 32'(count_o), 0);
    chk("arst.busy",  32'(busy_o),  0);
    chk("arst.tc",    32'(tc_o),    0);
    @(negedge clk_i); rst_ni = 1'b1;
    cyc("arel1", 1'b1, 1'b1, 1'b0, 8'd7);
    cyc("arel2", 1'b1, 1'b1, 1'b0, 8'd7);
    cyc("arel3", 1'b1, 1'b1, 1'b0, 8'd7);
    cyc("arun",  1'b0, 1'b1, 1'b0, 8'd0);

    chk("sb.empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of DATA, COUNT and the reload register.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of reset-synchronizer flops (minimum 2).
REQ-003 CLOCK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 ENABLE  input  1  count-down enable, sampled each rising edge.
REQ-006 LOAD  input  1  synchronous load of DATA, sampled each rising edge.
REQ-007 DATA  input  WIDTH  start/reload value, captured when LOAD=1.
REQ-008 RELOAD  input  1  auto-reload mode select, sampled at the terminal decrement.
REQ-009 COUNT  output  WIDTH  current count value, registered.
REQ-010 TC  output  1  terminal-count pulse, registered, one cycle wide.
REQ-011 BUSY  output  1  high while in state RUN, registered.

Function
REQ-012 Internal reset SHALL assert asynchronously on RESET=0 and deassert synchronously after SYNC_STAGES rising CLOCK edges with RESET=1.
REQ-013 States SHALL be IDLE, RUN and DONE, with IDLE entered on internal reset.
REQ-014 LOAD=1 in any state SHALL set COUNT<=DATA and reload register<=DATA; next state RUN if DATA!=0, else IDLE; TC<=0.
REQ-015 LOAD SHALL take priority over ENABLE and over a coincident terminal decrement (that decrement suppressed, no TC).
REQ-016 In RUN with LOAD=0, ENABLE=1 and COUNT>1, COUNT SHALL decrement by 1; TC<=0.
REQ-017 In RUN with LOAD=0, ENABLE=1, COUNT==1 and RELOAD=0: COUNT<=0, TC<=1 for one cycle, next state DONE.
REQ-018 In RUN with LOAD=0, ENABLE=1, COUNT==1 and RELOAD=1: COUNT<=reload register, TC<=1 for one cycle, remain RUN.
REQ-019 In RUN with ENABLE=0 and LOAD=0, COUNT SHALL hold and TC SHALL be 0.
REQ-020 In IDLE and DONE, ENABLE SHALL be ignored; COUNT holds; exit only via LOAD.
REQ-021 COUNT SHALL never wrap below 0 (no transition 0 -> 2^WIDTH-1).
REQ-022 Reload value 1 with RELOAD=1 and ENABLE held high SHALL produce TC=1 every cycle with COUNT constant at 1.
REQ-023 TC SHALL be 0 in every cycle not immediately following a terminal decrement.
REQ-024 BUSY SHALL equal 1 exactly when state is RUN, updated on the same edge as the state.
REQ-025 Load of DATA=2^WIDTH-1 SHALL count 255,254,...,1 then terminate per REQ-017/018 (WIDTH=8).

Reset
REQ-026 While internal reset is active: COUNT=0, TC=0, BUSY=0, reload register=0, state IDLE.
REQ-027 RESET=0 mid-count SHALL clear all outputs immediately without waiting for CLOCK.
REQ-028 LOAD and ENABLE SHALL have no effect until the internal reset has deasserted.

Verification
REQ-029 RESET low then released -> outputs 0 throughout; LOAD at the 1st post-release edge is ignored; LOAD at the 3rd post-release edge loads.
REQ-030 LOAD DATA=3, RELOAD=0, ENABLE=1 -> COUNT 3,2,1,0; TC=1 only in the cycle COUNT first reads 0; BUSY falls with it; COUNT stays 0 for 5 further cycles.
REQ-031 LOAD DATA=2, RELOAD=1, ENABLE=1 for 6 cycles -> COUNT 2,1,2,1,2,1 pattern; TC high in each cycle COUNT returns to 2; BUSY stays 1.
REQ-032 LOAD DATA=5, ENABLE toggled 1,0,1 -> COUNT 5,4,4,3; TC=0; then LOAD DATA=9 while COUNT==1 and ENABLE=1 -> COUNT=9, no TC.
REQ-033 LOAD DATA=0 -> COUNT=0, state IDLE, BUSY=0, TC never asserts under ENABLE=1.
REQ-034 RESET pulsed low asynchronously between edges during RUN at COUNT=0x80 -> COUNT=0, BUSY=0, TC=0 before the next CLOCK edge.
